// File: rtl/led_mode_ctrl_pkg.sv
// Shared definitions for the LED mode controller: mode codes, FSM state
// encoding and a counter-width helper used to size the cycle counters.
package led_mode_ctrl_pkg;

  // Mux select codes driven onto o_sel; 2'b11 is never produced.
  localparam logic [1:0] MODE_SHIFT  = 2'b00;
  localparam logic [1:0] MODE_FLASH  = 2'b01;
  localparam logic [1:0] MODE_SHIFT2 = 2'b10;

  // Controller FSM encoding.
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_BLANK = 1'b1;

  // Bits needed for a counter running 0..n-1 (minimum one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Mode rotation: shift -> flash -> shift2 -> shift.
  function automatic logic [1:0] next_mode(input logic [1:0] mode);
    logic [1:0] nxt;
    case (mode)
      MODE_SHIFT: nxt = MODE_FLASH;
      MODE_FLASH: nxt = MODE_SHIFT2;
      default:    nxt = MODE_SHIFT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/led_mode_ctrl_btn_debouncer.sv
// btn_debouncer: synchronizes the raw pushbutton, accepts a level change only
// after DEBOUNCE_CYCLES consecutive disagreeing samples, and emits a one-cycle
// press pulse on the accepted rising edge (release produces nothing).
// Ports:
//   i_clock  system clock
//   i_reset  asynchronous active-high reset
//   i_btn    raw, bouncing, asynchronous button level
//   o_press  registered one-cycle pulse per accepted press
module btn_debouncer
  import led_mode_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned   DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic [DB_W-1:0] r_cnt;
  logic            r_press;

  logic w_mismatch;
  logic w_flip;

  // The flip happens on the DEBOUNCE_CYCLES-th consecutive mismatch.
  assign w_mismatch = r_sync2 ^ r_level;
  assign w_flip     = w_mismatch && (r_cnt == DB_LAST);

  // Two-flop synchronizer into the clock domain.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Stability counter, debounced level and rising-edge pulse.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= w_flip & ~r_level;
      if (!w_mismatch || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
      if (w_flip) begin
        r_level <= ~r_level;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: turns debounced button presses and an optional auto-advance
// timer into mode advances for the LED output mux, blanking the LEDs for a
// fixed time after every switch.
// Ports:
//   i_clock     system clock
//   i_reset     asynchronous active-high reset
//   i_btn       raw pushbutton (bouncing, asynchronous)
//   i_auto_en   enables timer-driven auto advance
//   o_sel       mux select (00 shift, 01 flash, 10 shift2)
//   o_blank     forces LEDs off while high
//   o_advance   one-cycle pulse coincident with each o_sel change
//   o_mode_led  toggles on every advance
module led_mode_ctrl
  import led_mode_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned AUTO_PERIOD     = 50000000,
  parameter int unsigned BLANK_CYCLES    = 1000000
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_btn,
  input  logic       i_auto_en,
  output logic [1:0] o_sel,
  output logic       o_blank,
  output logic       o_advance,
  output logic       o_mode_led
);

  localparam int unsigned        AUTO_W     = cnt_width(AUTO_PERIOD);
  localparam int unsigned        BLANK_W    = cnt_width(BLANK_CYCLES);
  localparam logic [AUTO_W-1:0]  AUTO_LAST  = AUTO_W'(AUTO_PERIOD - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);

  logic [0:0]         r_state;
  logic [1:0]         r_sel;
  logic               r_blank;
  logic               r_advance;
  logic               r_mode_led;
  logic [AUTO_W-1:0]  r_auto_cnt;
  logic [BLANK_W-1:0] r_blank_cnt;

  logic [0:0]         w_state_nxt;
  logic [1:0]         w_sel_nxt;
  logic               w_blank_nxt;
  logic               w_advance_nxt;
  logic               w_mode_led_nxt;
  logic [AUTO_W-1:0]  w_auto_cnt_nxt;
  logic [BLANK_W-1:0] w_blank_cnt_nxt;

  logic w_press;
  logic w_expire;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debouncer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_btn   (i_btn),
    .o_press (w_press)
  );

  // Timer expiry only counts while auto mode is enabled.
  assign w_expire = i_auto_en && (r_auto_cnt == AUTO_LAST);

  // State and output registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_RUN;
      r_sel       <= MODE_SHIFT;
      r_blank     <= 1'b0;
      r_advance   <= 1'b0;
      r_mode_led  <= 1'b0;
      r_auto_cnt  <= '0;
      r_blank_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_blank     <= w_blank_nxt;
      r_advance   <= w_advance_nxt;
      r_mode_led  <= w_mode_led_nxt;
      r_auto_cnt  <= w_auto_cnt_nxt;
      r_blank_cnt <= w_blank_cnt_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_blank_nxt     = r_blank;
    w_advance_nxt   = 1'b0;
    w_mode_led_nxt  = r_mode_led;
    w_auto_cnt_nxt  = r_auto_cnt;
    w_blank_cnt_nxt = r_blank_cnt;

    case (r_state)
      ST_RUN: begin
        // A press coinciding with expiry still yields a single advance.
        if (w_press || w_expire) begin
          w_state_nxt     = ST_BLANK;
          w_sel_nxt       = next_mode(r_sel);
          w_advance_nxt   = 1'b1;
          w_mode_led_nxt  = ~r_mode_led;
          w_blank_nxt     = 1'b1;
          w_auto_cnt_nxt  = '0;
          w_blank_cnt_nxt = '0;
        end else if (i_auto_en) begin
          w_auto_cnt_nxt = r_auto_cnt + AUTO_W'(1);
        end else begin
          w_auto_cnt_nxt = '0;
        end
      end

      ST_BLANK: begin
        // Presses arriving here are dropped, not queued.
        w_auto_cnt_nxt = '0;
        if (r_blank_cnt == BLANK_LAST) begin
          w_state_nxt     = ST_RUN;
          w_blank_nxt     = 1'b0;
          w_blank_cnt_nxt = '0;
        end else begin
          w_blank_cnt_nxt = r_blank_cnt + BLANK_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign o_sel      = r_sel;
  assign o_blank    = r_blank;
  assign o_advance  = r_advance;
  assign o_mode_led = r_mode_led;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Randomized and directed bench for led_mode_ctrl with a behavioural model.
module tb_led_mode_ctrl;

  localparam int unsigned D = 4;
  localparam int unsigned P = 8;
  localparam int unsigned B = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       en;
  logic [1:0] o_sel;
  logic       o_blank;
  logic       o_advance;
  logic       o_mode_led;

  int n_vec = 0;
  int n_err = 0;
  int t_mode = 0;   // mode the bench expects at the end of each scenario
  bit t_led  = 1'b0;

  led_mode_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .AUTO_PERIOD    (P),
    .BLANK_CYCLES   (B)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_btn     (btn),
    .i_auto_en (en),
    .o_sel     (o_sel),
    .o_blank   (o_blank),
    .o_advance (o_advance),
    .o_mode_led(o_mode_led)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw button history, a "how long has the synced level
  // disagreed" run length, and mode/blank/timer bookkeeping as plain integers.
  bit hist0, hist1, m_db, m_event, m_inblank, mv_lvl, mv_ev, mv_exp;
  int m_streak, m_bleft, m_acnt, m_mode;
  bit m_blank, m_adv, m_led;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist0 = 0; hist1 = 0; m_db = 0; m_event = 0; m_inblank = 0;
      m_streak = 0; m_bleft = 0; m_acnt = 0; m_mode = 0;
      m_blank = 0; m_adv = 0; m_led = 0;
    end else begin
      mv_lvl = hist1;           // button level seen two edges ago
      hist1  = hist0;
      hist0  = btn;
      mv_ev  = m_event;         // press accepted on the previous edge
      if (mv_lvl != m_db) begin
        m_streak++;
        if (m_streak == int'(D)) begin
          m_db = mv_lvl; m_streak = 0; m_event = mv_lvl;
        end else m_event = 0;
      end else begin
        m_streak = 0; m_event = 0;
      end
      m_adv = 0;
      if (!m_inblank) begin
        mv_exp = en && (m_acnt == int'(P) - 1);
        if (mv_ev || mv_exp) begin
          m_mode = (m_mode + 1) % 3; m_adv = 1; m_led = ~m_led;
          m_acnt = 0; m_blank = 1; m_inblank = 1; m_bleft = int'(B);
        end else m_acnt = en ? m_acnt + 1 : 0;
      end else begin
        m_acnt = 0;
        m_bleft--;
        if (m_bleft == 0) begin m_blank = 0; m_inblank = 0; end
      end
    end
  end

  task automatic test_reset();
    if ({o_sel, o_blank, o_advance, o_mode_led} !== 5'b0) begin
      n_err++; $display("FAIL reset_state got %b exp 00000", {o_sel, o_blank, o_advance, o_mode_led});
    end
    n_vec++;
    btn = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if ({o_sel, o_blank, o_advance, o_mode_led} !== {2'(m_mode), m_blank, m_adv, m_led}) begin
        n_err++; $display("FAIL model_reset k=%0d got %b exp %b", k,
          {o_sel, o_blank, o_advance, o_mode_led}, {2'(m_mode), m_blank, m_adv, m_led});
      end
      n_vec++;
    end
    if (o_sel !== 2'b01 || o_blank !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_blank sel=%b blank=%b exp 01/1", o_sel, o_blank);
    end
    n_vec++;
    btn = 1'b0;
    #2 rst = 1'b1;
    #1;
    if ({o_sel, o_blank, o_advance, o_mode_led} !== 5'b0) begin
      n_err++; $display("FAIL async_reset got %b exp 00000", {o_sel, o_blank, o_advance, o_mode_led});
    end
    n_vec++;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ({o_sel, o_blank, o_advance, o_mode_led} !== {2'(m_mode), m_blank, m_adv, m_led}) begin
        n_err++; $display("FAIL model_post_reset k=%0d got %b exp %b", k,
          {o_sel, o_blank, o_advance, o_mode_led}, {2'(m_mode), m_blank, m_adv, m_led});
      end
      n_vec++;
    end
    t_mode = 0; t_led = 0;
  endtask

  // Clean press from mode 00: advance visible after the 7th negedge (edge e0+6).
  task automatic test_clean_press();
    logic [4:0] exp_v;
    btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_v = {(k >= 7) ? 2'b01 : 2'b00, (k == 7 || k == 8), (k == 7), (k >= 7)};
      if ({o_sel, o_blank, o_advance, o_mode_led} !== exp_v) begin
        n_err++; $display("FAIL clean_press k=%0d got %b exp %b", k,
          {o_sel, o_blank, o_advance, o_mode_led}, exp_v);
      end
      n_vec++;
    end
    btn = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge clk);
    if ({o_sel, o_blank, o_advance, o_mode_led} !== {2'(m_mode), m_blank, m_adv, m_led}) begin
      n_err++; $display("FAIL model_clean_release got %b exp %b",
        {o_sel, o_blank, o_advance, o_mode_led}, {2'(m_mode), m_blank, m_adv, m_led});
    end
    n_vec++;
    t_mode = 1; t_led = 1;
  endtask

  task automatic test_bounce();
    bit pat[6] = '{1, 0, 1, 1, 0, 1};
    int n_adv = 0;
    int first_k = -1;
    for (int k = 1; k <= 20; k++) begin
      btn = (k <= 6) ? pat[k-1] : 1'b1;
      @(negedge clk);
      if (o_advance === 1'b1) begin n_adv++; if (first_k < 0) first_k = k; end
      if ({o_sel, o_blank, o_advance, o_mode_led} !== {2'(m_mode), m_blank, m_adv, m_led}) begin
        n_err++; $display("FAIL model_bounce k=%0d got %b exp %b", k,
          {o_sel, o_blank, o_advance, o_mode_led}, {2'(m_mode), m_blank, m_adv, m_led});
      end
      n_vec++;
    end
    t_mode = (t_mode + 1) % 3; t_led = ~t_led;
    if (n_adv != 1 || first_k != 12 || o_sel !== 2'(t_mode)) begin
      n_err++; $display("FAIL bounce_once advances=%0d at_k=%0d sel=%b exp 1/12/%0d", n_adv, first_k, o_sel, t_mode);
    end
    n_vec++;
    btn = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge clk);
    n_adv = 0;
    for (int k = 1; k <= 15; k++) begin
      btn = (k <= 3);
      @(negedge clk);
      if (o_advance === 1'b1) n_adv++;
    end
    if (n_adv != 0 || o_sel !== 2'(t_mode)) begin
      n_err++; $display("FAIL glitch_ignored advances=%0d sel=%b exp 0/%0d", n_adv, o_sel, t_mode);
    end
    n_vec++;
  endtask

  task automatic test_wrap();
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 18; k++) begin
        btn = (k < 8);
        @(negedge clk);
        if (o_sel === 2'b11) begin
          n_err++; $display("FAIL sel_illegal got %b exp not 11", o_sel);
        end
        n_vec++;
        if ({o_sel, o_blank, o_advance, o_mode_led} !== {2'(m_mode), m_blank, m_adv, m_led}) begin
          n_err++; $display("FAIL model_wrap p=%0d k=%0d got %b exp %b", p, k,
            {o_sel, o_blank, o_advance, o_mode_led}, {2'(m_mode), m_blank, m_adv, m_led});
        end
        n_vec++;
      end
      t_mode = (t_mode + 1) % 3; t_led = ~t_led;
      if (o_sel !== 2'(t_mode) || o_mode_led !== t_led) begin
        n_err++; $display("FAIL wrap_step p=%0d sel=%b led=%b exp %0d/%b", p, o_sel, o_mode_led, t_mode, t_led);
      end
      n_vec++;
    end
  endtask

  task automatic test_auto();
    bit exp_adv;
    en = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      exp_adv = (k >= 8) && ((k - 8) % 10 == 0);
      if (o_advance !== exp_adv) begin
        n_err++; $display("FAIL auto_period k=%0d got %b exp %b", k, o_advance, exp_adv);
      end
      n_vec++;
      if (exp_adv) t_mode = (t_mode + 1) % 3;
    end
    en = 1'b0;   // timer sits at 5 here
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (o_advance !== 1'b0) begin
        n_err++; $display("FAIL auto_disabled k=%0d got %b exp 0", k, o_advance);
      end
      n_vec++;
    end
    en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (o_advance !== (k == 8)) begin
        n_err++; $display("FAIL auto_restart k=%0d got %b exp %b", k, o_advance, (k == 8));
      end
      n_vec++;
    end
    t_mode = (t_mode + 1) % 3;
    en = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    if (o_sel !== 2'(t_mode)) begin
      n_err++; $display("FAIL auto_mode sel=%b exp %0d", o_sel, t_mode);
    end
    n_vec++;
  endtask

  // Press lands on timer expiry (j=10), then a press lands in BLANK (j=21).
  task automatic test_coincide();
    en = 1'b1;
    for (int k = 1; k <= 8; k++) @(negedge clk);
    if (o_advance !== 1'b1) begin
      n_err++; $display("FAIL coincide_sync got %b exp 1", o_advance);
    end
    n_vec++;
    t_mode = (t_mode + 1) % 3;
    for (int j = 1; j <= 29; j++) begin
      @(negedge clk);
      if (o_advance !== (j == 10 || j == 20)) begin
        n_err++; $display("FAIL coincide_adv j=%0d got %b exp %b", j, o_advance, (j == 10 || j == 20));
      end
      n_vec++;
      if ({o_sel, o_blank, o_advance, o_mode_led} !== {2'(m_mode), m_blank, m_adv, m_led}) begin
        n_err++; $display("FAIL model_coincide j=%0d got %b exp %b", j,
          {o_sel, o_blank, o_advance, o_mode_led}, {2'(m_mode), m_blank, m_adv, m_led});
      end
      n_vec++;
      if (j == 3 || j == 14) btn = 1'b1;
      if (j == 8) btn = 1'b0;
    end
    t_mode = (t_mode + 2) % 3;
    if (o_sel !== 2'(t_mode)) begin
      n_err++; $display("FAIL blank_press_dropped sel=%b exp %0d", o_sel, t_mode);
    end
    n_vec++;
    btn = 1'b0; en = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge clk);
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 5) == 0) btn = ~btn;
      if ($urandom_range(0, 99) == 0) en = ~en;
      @(negedge clk);
      if ({o_sel, o_blank, o_advance, o_mode_led} !== {2'(m_mode), m_blank, m_adv, m_led}) begin
        n_err++; $display("FAIL model_random k=%0d got %b exp %b", k,
          {o_sel, o_blank, o_advance, o_mode_led}, {2'(m_mode), m_blank, m_adv, m_led});
      end
      n_vec++;
    end
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_wrap();
    test_auto();
    test_coincide();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
